// File: rtl/cpu_wb_writer_pkg.sv
// Shared types and constants for the writeback stage.
package cpu_wb_writer_pkg;
  localparam int WB_NUM_W  = 5;
  localparam int WB_DATA_W = 32;
  localparam logic [WB_NUM_W-1:0] REG_ZERO = 5'h0;

  typedef struct packed {
    logic [WB_NUM_W-1:0]  num;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/cpu_wb_writer_result_fifo.sv
// Small FIFO holding long-latency results until the write port is free.
module wb_result_fifo
  import cpu_wb_writer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      clr,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets pointers wrap by natural overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/cpu_wb_writer.sv
// Writeback stage: arbitrates MEM and queued LU results onto the regfile
// write port and tracks in-flight LU destinations to stall ID.
module cpu_wb_writer
  import cpu_wb_writer_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int NREGS    = 32
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mem_reg_write_en,
  input  logic [4:0]  mem_reg_write_num,
  input  logic [31:0] mem_reg_write_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_num,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_num,
  input  logic [31:0] lu_data,
  input  logic [4:0]  reg_read1_num_realtime,
  input  logic [4:0]  reg_read2_num_realtime,
  input  logic [4:0]  id_dest_num,
  output logic        reg_write_en,
  output logic [4:0]  reg_write_num,
  output logic [31:0] reg_write_data,
  output logic        stall
);
  logic             mem_wr, fifo_push, fifo_pop, fifo_full, fifo_empty, issue_ok;
  wb_entry_t        fifo_head, fifo_din;
  logic [NREGS-1:0] pending_q, pending_d;
  logic             wen_q, wen_d;
  logic [4:0]       wnum_q, wnum_d;
  logic [31:0]      wdata_q, wdata_d;

  assign mem_wr    = mem_reg_write_en && (mem_reg_write_num != REG_ZERO);
  assign lu_ready  = !fifo_full;
  assign fifo_push = lu_valid && lu_ready;
  // Pop decision uses pre-edge emptiness, so a fresh push never bypasses.
  assign fifo_pop  = !mem_wr && !fifo_empty;
  assign fifo_din  = '{num: lu_num, data: lu_data};

  wb_result_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    stall = 1'b0;
    if (pending_q[reg_read1_num_realtime] && reg_read1_num_realtime != REG_ZERO) stall = 1'b1;
    if (pending_q[reg_read2_num_realtime] && reg_read2_num_realtime != REG_ZERO) stall = 1'b1;
    if (pending_q[id_dest_num] && id_dest_num != REG_ZERO) stall = 1'b1;
    if (lu_issue && pending_q[lu_issue_num] && lu_issue_num != REG_ZERO) stall = 1'b1;
  end

  assign issue_ok = lu_issue && !stall && (lu_issue_num != REG_ZERO);

  // Set is applied after clear so a same-cycle reissue stays pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop) pending_d[fifo_head.num] = 1'b0;
    if (issue_ok) pending_d[lu_issue_num] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    wen_d   = 1'b0;
    wnum_d  = '0;
    wdata_d = '0;
    if (mem_wr) begin
      wen_d   = 1'b1;
      wnum_d  = mem_reg_write_num;
      wdata_d = mem_reg_write_data;
    end else if (fifo_pop) begin
      wen_d   = 1'b1;
      wnum_d  = fifo_head.num;
      wdata_d = fifo_head.data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pending_q <= '0;
      wen_q     <= 1'b0;
      wnum_q    <= '0;
      wdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      wen_q     <= wen_d;
      wnum_q    <= wnum_d;
      wdata_q   <= wdata_d;
    end
  end

  assign reg_write_en   = wen_q;
  assign reg_write_num  = wnum_q;
  assign reg_write_data = wdata_q;
endmodule
